// File: rtl/spi_cmd_pkg.sv
// Shared types and constants for the SPI command dispatcher: session FSM
// encoding, the fill patterns that mark an illegal command code, and the drop counter ceiling.
package spi_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FAULT  = 2'd2
  } state_e;

  // A command code made entirely of one of these bits is never executed.
  localparam logic CODE_FILL_ZERO = 1'b0;
  localparam logic CODE_FILL_ONE  = 1'b1;

  localparam int DROP_W   = 8;
  localparam int DROP_MAX = 255;

endpackage

// File: rtl/cmd_sync_fifo.sv
// Synchronous FIFO with a registered head entry: a push into an empty FIFO
// shows up on the head one cycle later. Flush clears the pointers and the head entry.
module cmd_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] rdata_o,
  output logic [AW:0]      level_o,
  output logic             full_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             pop_en;

  assign level_o = wr_q - rd_q;
  assign valid_o = (wr_q != rd_q);
  assign full_o  = (level_o == (AW+1)'(DEPTH));
  assign rdata_o = head_q;
  assign pop_en  = pop_i & valid_o;

  // The head reloads only when it is consumed or when it is being created.
  // If the entry that becomes the head is the one written this cycle, take it from wdata_i.
  always_comb begin
    wr_d   = wr_q + (AW+1)'(push_i);
    rd_d   = rd_q + (AW+1)'(pop_en);
    head_d = head_q;
    if (push_i && (rd_d == wr_q)) begin
      head_d = wdata_i;
    end else if (pop_en) begin
      head_d = mem_q[rd_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) begin
      mem_q[wr_q[AW-1:0]] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      wr_q   <= '0;
      rd_q   <= '0;
      head_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      head_q <= head_d;
    end
  end

endmodule

// File: rtl/spi_cmd_dispatcher.sv
// Captures comparator-flagged SPI command frames into a FIFO. It also tracks
// the session state, drops illegal or overflowing commands, and reports the last executed sequence id.
module spi_cmd_dispatcher
  import spi_cmd_pkg::*;
#(
  parameter int SEQ_W  = 2,
  parameter int CMD_W  = 8,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seq_diff,
  input  logic              seq_reset,
  input  logic [SEQ_W-1:0]  seq_id,
  input  logic [CMD_W-1:0]  cmd_code,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SEQ_W-1:0]  out_seq,
  output logic [CMD_W-1:0]  out_code,
  output logic [DATA_W-1:0] out_data,
  output logic [SEQ_W-1:0]  ack_seq,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              overflow,
  output logic              illegal,
  output logic [7:0]        drop_cnt
);

  localparam int ENTRY_W = SEQ_W + CMD_W + DATA_W;

  state_e            state_q, state_d;
  logic              illegal_q, illegal_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic [SEQ_W-1:0]  ack_q, ack_d;

  logic diff_live, qual_push, code_bad, pop, push_wr, ovf_evt, drop_evt;
  logic fifo_full;

  assign diff_live = seq_diff & ~seq_reset;
  assign qual_push = diff_live & (state_q != ST_FAULT);
  assign code_bad  = (cmd_code == {CMD_W{CODE_FILL_ZERO}}) ||
                     (cmd_code == {CMD_W{CODE_FILL_ONE}});
  assign pop       = out_valid & out_ready;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_wr  = qual_push & ~code_bad & (~fifo_full | pop);
  assign ovf_evt  = qual_push & ~code_bad & fifo_full & ~pop;
  assign drop_evt = (qual_push & code_bad) | ovf_evt |
                    (diff_live & (state_q == ST_FAULT));

  cmd_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (seq_reset),
    .push_i  (push_wr),
    .wdata_i ({seq_id, cmd_code, cmd_data}),
    .pop_i   (out_ready),
    .valid_o (out_valid),
    .rdata_o ({out_seq, out_code, out_data}),
    .level_o (fifo_level),
    .full_o  (fifo_full)
  );

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    drop_d    = drop_q;
    ack_d     = ack_q;
    if (seq_reset) begin
      state_d   = ST_IDLE;
      illegal_d = 1'b0;
      drop_d    = '0;
      ack_d     = '0;
    end else begin
      if (ovf_evt) begin
        state_d = ST_FAULT;
      end else if (push_wr && state_q == ST_IDLE) begin
        state_d = ST_ACTIVE;
      end
      if (qual_push && code_bad) begin
        illegal_d = 1'b1;
      end
      if (drop_evt && drop_q != DROP_W'(DROP_MAX)) begin
        drop_d = drop_q + DROP_W'(1);
      end
      if (pop) begin
        ack_d = out_seq;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      illegal_q <= 1'b0;
      drop_q    <= '0;
      ack_q     <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      drop_q    <= drop_d;
      ack_q     <= ack_d;
    end
  end

  assign overflow = (state_q == ST_FAULT);
  assign illegal  = illegal_q;
  assign drop_cnt = drop_q;
  assign ack_seq  = ack_q;

endmodule

// File: tb/tb_spi_cmd_dispatcher.sv
// Directed bench for spi_cmd_dispatcher. A queue-based model predicts every
// output after each clock edge, and literal expectations pin key points.
module tb_spi_cmd_dispatcher;

  localparam int SEQ_W  = 2;
  localparam int CMD_W  = 8;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int LVL_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              seq_diff = 1'b0;
  logic              seq_reset = 1'b1;
  logic [SEQ_W-1:0]  seq_id = '0;
  logic [CMD_W-1:0]  cmd_code = '0;
  logic [DATA_W-1:0] cmd_data = '0;
  logic              out_ready = 1'b0;
  logic              out_valid;
  logic [SEQ_W-1:0]  out_seq;
  logic [CMD_W-1:0]  out_code;
  logic [DATA_W-1:0] out_data;
  logic [SEQ_W-1:0]  ack_seq;
  logic [LVL_W-1:0]  fifo_level;
  logic              overflow;
  logic              illegal;
  logic [7:0]        drop_cnt;

  spi_cmd_dispatcher #(
    .SEQ_W(SEQ_W), .CMD_W(CMD_W), .DATA_W(DATA_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .seq_diff(seq_diff), .seq_reset(seq_reset),
    .seq_id(seq_id), .cmd_code(cmd_code), .cmd_data(cmd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_seq(out_seq),
    .out_code(out_code), .out_data(out_data), .ack_seq(ack_seq),
    .fifo_level(fifo_level), .overflow(overflow), .illegal(illegal),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [SEQ_W-1:0]  s;
    logic [CMD_W-1:0]  c;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t mq[$];
  int   m_ack = 0;
  int   m_fault = 0;
  int   m_ill = 0;
  int   m_drop = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic bump_drop();
    if (m_drop < 255) m_drop++;
  endtask

  // Apply the rules for one clock edge to the model, using the inputs now on the pins.
  task automatic model_edge();
    ent_t e;
    if (!rst_n || seq_reset) begin
      mq.delete();
      m_ack = 0; m_fault = 0; m_ill = 0; m_drop = 0;
      return;
    end
    if (mq.size() > 0 && out_ready) begin
      e = mq.pop_front();
      m_ack = e.s;
    end
    if (seq_diff) begin
      if (m_fault != 0) bump_drop();
      else if (cmd_code == 8'h00 || cmd_code == 8'hFF) begin
        m_ill = 1;
        bump_drop();
      end else if (mq.size() < DEPTH) begin
        e.s = seq_id; e.c = cmd_code; e.d = cmd_data;
        mq.push_back(e);
      end else begin
        m_fault = 1;
        bump_drop();
      end
    end
  endtask

  task automatic compare();
    check("out_valid", out_valid, (mq.size() > 0) ? 1 : 0);
    check("fifo_level", fifo_level, mq.size());
    check("ack_seq", ack_seq, m_ack);
    check("overflow", overflow, m_fault);
    check("illegal", illegal, m_ill);
    check("drop_cnt", drop_cnt, m_drop);
    if (mq.size() > 0) begin
      check("out_seq", out_seq, mq[0].s);
      check("out_code", out_code, mq[0].c);
      check("out_data", out_data, mq[0].d);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic change(input logic [SEQ_W-1:0] id, input logic [CMD_W-1:0] code,
                        input logic [DATA_W-1:0] data);
    seq_id    = id;
    cmd_code  = code;
    cmd_data  = data;
    seq_diff  = 1'b1;
    seq_reset = (id == '0);
    step();
    seq_diff  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  initial begin
    // Reset
    idle(2);
    check("rst_valid", out_valid, 0);
    check("rst_seq", out_seq, 0);
    check("rst_code", out_code, 0);
    check("rst_data", out_data, 0);
    check("rst_level", fifo_level, 0);
    check("rst_drop", drop_cnt, 0);
    rst_n = 1'b1;
    idle(1);

    // First command, dispatched one cycle after the push
    out_ready = 1'b1;
    change(2'd1, 8'h12, 32'hDEADBEEF);
    check("t1_valid", out_valid, 1);
    check("t1_seq", out_seq, 1);
    check("t1_code", out_code, 8'h12);
    check("t1_data", out_data, 32'hDEADBEEF);
    step();
    check("t1_ack", ack_seq, 1);
    check("t1_empty", out_valid, 0);

    // Stall, fill, overflow, drain
    out_ready = 1'b0;
    change(2'd2, 8'h21, 32'h1);
    change(2'd3, 8'h31, 32'h2);
    change(2'd1, 8'h41, 32'h3);
    change(2'd2, 8'h51, 32'h4);
    check("t2_level", fifo_level, 4);
    check("t2_head", out_seq, 2);
    idle(2);
    change(2'd3, 8'h61, 32'h5);
    check("t2_ovf", overflow, 1);
    check("t2_drop1", drop_cnt, 1);
    change(2'd1, 8'h71, 32'h6);
    check("t2_drop2", drop_cnt, 2);
    out_ready = 1'b1;
    idle(5);
    check("t2_drained", fifo_level, 0);
    check("t2_ack", ack_seq, 2);
    change(2'd0, 8'h10, 32'h0);

    // Push into a full FIFO while it pops
    out_ready = 1'b0;
    change(2'd1, 8'h11, 32'h11);
    change(2'd2, 8'h12, 32'h12);
    change(2'd3, 8'h13, 32'h13);
    change(2'd1, 8'h14, 32'h14);
    out_ready = 1'b1;
    change(2'd2, 8'h15, 32'h15);
    check("t3_level", fifo_level, 4);
    check("t3_noovf", overflow, 0);
    idle(6);

    // Illegal codes
    change(2'd3, 8'hFF, 32'hAA);
    check("t4_novalid", out_valid, 0);
    check("t4_illegal", illegal, 1);
    check("t4_drop", drop_cnt, 1);
    change(2'd1, 8'h05, 32'hBB);
    check("t4_valid", out_valid, 1);
    check("t4_code", out_code, 8'h05);
    idle(2);
    change(2'd2, 8'h00, 32'hCC);
    check("t4_drop2", drop_cnt, 2);

    // Sequence reset with entries queued
    out_ready = 1'b0;
    change(2'd3, 8'h23, 32'h23);
    change(2'd1, 8'h24, 32'h24);
    change(2'd2, 8'h25, 32'h25);
    check("t5_level3", fifo_level, 3);
    out_ready = 1'b1;
    change(2'd0, 8'h77, 32'h77);
    check("t5_valid", out_valid, 0);
    check("t5_level", fifo_level, 0);
    check("t5_ill", illegal, 0);
    check("t5_drop", drop_cnt, 0);
    check("t5_ack", ack_seq, 0);

    // rst_n pulse mid-stream
    out_ready = 1'b0;
    change(2'd1, 8'hFF, 32'h0);
    change(2'd2, 8'h32, 32'h32);
    change(2'd3, 8'h33, 32'h33);
    change(2'd1, 8'h34, 32'h34);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    change(2'd2, 8'h35, 32'h35);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("t6_valid", out_valid, 0);
    check("t6_level", fifo_level, 0);
    check("t6_ill", illegal, 0);
    check("t6_ack", ack_seq, 0);

    // Drop counter saturation while in FAULT
    change(2'd3, 8'h41, 32'h41);
    change(2'd1, 8'h42, 32'h42);
    change(2'd2, 8'h43, 32'h43);
    change(2'd3, 8'h44, 32'h44);
    change(2'd1, 8'h45, 32'h45);
    for (int i = 0; i < 260; i++) begin
      change((i % 2 == 0) ? 2'd2 : 2'd1, 8'h46, 32'(i));
    end
    check("t7_sat", drop_cnt, 255);
    check("t7_kept", fifo_level, 4);
    change(2'd0, 8'h00, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
